// File: rtl/prbs16_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR generator/checker pair.
// Holds the state encoding, the default tap mask and the LFSR step function.
package prbs16_pkg;

  localparam int unsigned LfsrWidth = 16;
  localparam logic [LfsrWidth-1:0] DefaultTapMask = 16'hB400;

  typedef logic [1:0] state_t;
  localparam state_t StIdle    = 2'd0;
  localparam state_t StHunt    = 2'd1;
  localparam state_t StConfirm = 2'd2;
  localparam state_t StLocked  = 2'd3;

  function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] s,
                                                     input logic [LfsrWidth-1:0] mask);
    return {s[LfsrWidth-2:0], ^(s & mask)};
  endfunction

endpackage

// File: rtl/prbs16_checker_if.sv
// Received word stream into the checker: a valid qualifier and the data word.
interface prbs16_checker_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prbs16_checker.sv
// PRBS16 receive checker: seeds from the stream, confirms lock, then flywheels
// the LFSR and reports mismatches, lock loss and word/error statistics.
module prbs16_checker
  import prbs16_pkg::*;
#(
  parameter int unsigned      WIDTH           = 16,
  parameter logic [WIDTH-1:0] TAP_MASK        = DefaultTapMask,
  parameter int unsigned      LOCK_MATCHES    = 4,
  parameter int unsigned      LOSS_MISMATCHES = 4,
  parameter int unsigned      CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  prbs16_checker_if.slave  in_if,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic             zero_seen
);

  localparam logic [3:0] LockLast = 4'(LOCK_MATCHES - 1);
  localparam logic [3:0] LossLast = 4'(LOSS_MISMATCHES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             locked_q, err_pulse_q, zero_seen_q;
  logic             err_inc, word_inc, zero_hit;
  logic             data_zero, data_match;

  assign data_zero  = (in_if.in_data == '0);
  assign data_match = (in_if.in_data == ref_q);

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_inc  = 1'b0;
    word_inc = 1'b0;
    zero_hit = 1'b0;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StHunt;
        StHunt: begin
          if (in_if.in_valid) begin
            if (data_zero) begin
              zero_hit = 1'b1;
            end else begin
              ref_d   = lfsr_next(in_if.in_data, TAP_MASK);
              match_d = '0;
              state_d = StConfirm;
            end
          end
        end
        StConfirm: begin
          if (in_if.in_valid) begin
            if (data_zero) begin
              zero_hit = 1'b1;
              state_d  = StHunt;
            end else begin
              // A mismatching nonzero word becomes the new seed.
              ref_d = lfsr_next(in_if.in_data, TAP_MASK);
              if (!data_match) begin
                match_d = '0;
              end else if (match_q == LockLast) begin
                match_d = '0;
                miss_d  = '0;
                state_d = StLocked;
              end else begin
                match_d = match_q + 1'b1;
              end
            end
          end
        end
        default: begin
          if (in_if.in_valid) begin
            // Flywheel on our own prediction; never reseed from received data.
            ref_d    = lfsr_next(ref_q, TAP_MASK);
            word_inc = 1'b1;
            zero_hit = data_zero;
            if (data_match) begin
              miss_d = '0;
            end else begin
              err_inc = 1'b1;
              if (miss_q == LossLast) begin
                miss_d  = '0;
                state_d = StHunt;
              end else begin
                miss_d = miss_q + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ref_q       <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      zero_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= (state_d == StLocked);
      err_pulse_q <= err_inc;
      zero_seen_q <= clear ? 1'b0 : (zero_seen_q | zero_hit);
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (clear),
    .cnt (err_count)
  );

  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk (clk),
    .rst (rst),
    .inc (word_inc),
    .clr (clear),
    .cnt (word_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign zero_seen = zero_seen_q;

endmodule
